// File: rtl/ibuf_sync_if.sv
// Pin-side bundle for ibuf_sync: the raw pin, its pass-through and the
// conditioned osc-domain view (level, edge pulses, stability, edge count).
// master = board/pin side and consumer, slave = the ibuf_sync block.
interface ibuf_sync_if #(
  parameter int unsigned CNT_W = 16
);
  logic             I;
  logic             O;
  logic             sync_o;
  logic             rise;
  logic             fall;
  logic             stable;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output I,
    input  O, sync_o, rise, fall, stable, edge_cnt
  );

  modport slave (
    input  I,
    output O, sync_o, rise, fall, stable, edge_cnt
  );
endinterface

// File: rtl/ibuf_sync.sv
// ibuf_sync: input buffer and conditioner for one asynchronous board pin.
// O is a combinational pass-through of I. In the osc domain the pin is run
// through a SYNC_STAGES-deep synchronizer, an optional glitch filter, and a
// level register that produces sync_o plus registered rise/fall pulses and a
// wrapping rising-edge counter.
// Optional feature macro: IBUF_SYNC_FILTER_EN (glitch filter of FILTER_CYCLES).
module ibuf_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 24,
  parameter int unsigned CNT_W         = 16
) (
  input  logic     osc,
  input  logic     rst,
  ibuf_sync_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("ibuf_sync: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
    $error("ibuf_sync: FILTER_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] s;
  logic                   s_last;
  logic                   lvl;
  logic                   lvl_next;
  logic                   rise_q;
  logic                   fall_q;
  logic                   stable_q;
  logic                   stable_next;
  logic [CNT_W-1:0]       cnt_q;

  // Raw pass-through, independent of osc and rst.
  assign bus.O = bus.I;

  assign s_last = s[SYNC_STAGES-1];

  // Synchronizer shift chain; s[0] captures the asynchronous pin.
  always_ff @(posedge osc) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], bus.I};
    end
  end

`ifdef IBUF_SYNC_FILTER_EN
  localparam int unsigned FW = (FILTER_CYCLES + 1 > 1) ? $clog2(FILTER_CYCLES + 1) : 1;

  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_next;

  // Glitch filter: accept a new level only after FILTER_CYCLES consecutive
  // mismatch cycles; any agreeing cycle restarts the count.
  always_comb begin
    lvl_next  = lvl;
    fcnt_next = '0;
    if (s_last != lvl) begin
      if (fcnt == FW'(FILTER_CYCLES - 1)) begin
        lvl_next  = s_last;
        fcnt_next = '0;
      end else begin
        fcnt_next = fcnt + 1'b1;
      end
    end
  end

  // Filter counter register; reset discards any count in progress.
  always_ff @(posedge osc) begin
    if (rst) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt_next;
    end
  end

  assign stable_next = (s_last == lvl_next) && (fcnt_next == '0);
`else
  // Without the filter the level follows the last synchronizer stage directly.
  always_comb begin
    lvl_next = s_last;
  end

  assign stable_next = (s_last == lvl_next);
`endif

  // Level, edge pulses, stability flag and rising-edge counter all come from
  // the same lvl/lvl_next compare so they change together with sync_o.
  always_ff @(posedge osc) begin
    if (rst) begin
      lvl      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      lvl      <= lvl_next;
      rise_q   <= ~lvl & lvl_next;
      fall_q   <= lvl & ~lvl_next;
      stable_q <= stable_next;
      if (~lvl & lvl_next) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.sync_o   = lvl;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.stable   = stable_q;
  assign bus.edge_cnt = cnt_q;

endmodule

// File: tb/tb_ibuf_sync.sv
// Directed testbench for ibuf_sync: pass-through, sync latency, edge pulses,
// counter wrap, mid-operation reset and (with IBUF_SYNC_FILTER_EN) the filter.
module tb_ibuf_sync;

  logic osc = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 osc = ~osc;

  // Main DUT (FILTER_CYCLES=1 behaves as unfiltered in either build).
  ibuf_sync_if #(.CNT_W(16)) bus ();
  ibuf_sync #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .CNT_W(16)) dut (
    .osc(osc), .rst(rst), .bus(bus)
  );

  // Narrow counter DUT for the wrap test.
  ibuf_sync_if #(.CNT_W(4)) bus4 ();
  ibuf_sync #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .CNT_W(4)) dut4 (
    .osc(osc), .rst(rst), .bus(bus4)
  );

  // Long-filter DUT (only filters when the macro is defined).
  ibuf_sync_if #(.CNT_W(16)) busf ();
  ibuf_sync #(.SYNC_STAGES(2), .FILTER_CYCLES(24), .CNT_W(16)) dutf (
    .osc(osc), .rst(rst), .bus(busf)
  );

  assign bus.I  = pin;
  assign bus4.I = pin;
  assign busf.I = pin;

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pin = 1'b0;
    do_reset();
    checks++; if (bus.sync_o !== 1'b0) begin failures++; $display("FAIL reset_sync_o got=%b exp=0", bus.sync_o); end
    checks++; if ({bus.rise, bus.fall} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bus.rise, bus.fall}); end
    checks++; if (bus.edge_cnt !== 16'd0) begin failures++; $display("FAIL reset_edge_cnt got=%0d exp=0", bus.edge_cnt); end
    checks++; if (bus.stable !== 1'b1) begin failures++; $display("FAIL reset_stable got=%b exp=1", bus.stable); end
    checks++; if (bus.O !== 1'b0) begin failures++; $display("FAIL reset_O got=%b exp=0", bus.O); end
  endtask

  task automatic test_rise();
    pin = 1'b1;
    #1;
    checks++; if (bus.O !== 1'b1) begin failures++; $display("FAIL rise_O_comb got=%b exp=1", bus.O); end
    tick(); tick();
    checks++; if ({bus.sync_o, bus.rise} !== 2'b00) begin failures++; $display("FAIL rise_edge2 got=%b exp=00", {bus.sync_o, bus.rise}); end
    tick();
    checks++; if ({bus.sync_o, bus.rise, bus.fall} !== 3'b110) begin failures++; $display("FAIL rise_edge3 got=%b exp=110", {bus.sync_o, bus.rise, bus.fall}); end
    checks++; if (bus.stable !== 1'b1) begin failures++; $display("FAIL rise_stable got=%b exp=1", bus.stable); end
    tick();
    checks++; if ({bus.sync_o, bus.rise} !== 2'b10) begin failures++; $display("FAIL rise_edge4 got=%b exp=10", {bus.sync_o, bus.rise}); end
    checks++; if (bus.edge_cnt !== 16'd1) begin failures++; $display("FAIL rise_edge_cnt got=%0d exp=1", bus.edge_cnt); end
  endtask

  task automatic test_toggle();
    int rise_n = 0;
    int fall_n = 0;
    int rise_at = -1;
    int fall_at = -1;
    int both = 0;
    pin = 1'b0;
    do_reset();
    pin = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) pin = 1'b0;
      tick();
      if (bus.rise === 1'b1) begin rise_n++; rise_at = k; end
      if (bus.fall === 1'b1) begin fall_n++; fall_at = k; end
      if (bus.rise === 1'b1 && bus.fall === 1'b1) both++;
    end
    checks++; if (rise_n != 1 || rise_at != 3) begin failures++; $display("FAIL toggle_rise got n=%0d at=%0d exp n=1 at=3", rise_n, rise_at); end
    checks++; if (fall_n != 1 || fall_at != 13) begin failures++; $display("FAIL toggle_fall got n=%0d at=%0d exp n=1 at=13", fall_n, fall_at); end
    checks++; if (both != 0) begin failures++; $display("FAIL toggle_both got=%0d exp=0", both); end
    checks++; if (bus.edge_cnt !== 16'd1) begin failures++; $display("FAIL toggle_edge_cnt got=%0d exp=1", bus.edge_cnt); end
    checks++; if (bus.sync_o !== 1'b0) begin failures++; $display("FAIL toggle_sync_o got=%b exp=0", bus.sync_o); end
  endtask

  task automatic test_wrap();
    pin = 1'b0;
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      pin = 1'b1;
      repeat (4) tick();
      pin = 1'b0;
      repeat (4) tick();
      if (p == 15) begin
        checks++; if (bus4.edge_cnt !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", bus4.edge_cnt); end
      end
      if (p == 16) begin
        checks++; if (bus4.edge_cnt !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", bus4.edge_cnt); end
      end
    end
    checks++; if (bus4.edge_cnt !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", bus4.edge_cnt); end
    checks++; if (bus.edge_cnt !== 16'd17) begin failures++; $display("FAIL wrap_wide got=%0d exp=17", bus.edge_cnt); end
  endtask

  task automatic test_reset_mid();
    pin = 1'b0;
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      pin = 1'b1;
      repeat (4) tick();
      pin = 1'b0;
      repeat (4) tick();
    end
    pin = 1'b1;
    repeat (5) tick();
    checks++; if ({bus.sync_o, bus.edge_cnt} !== {1'b1, 16'd5}) begin failures++; $display("FAIL mid_pre got sync=%b cnt=%0d exp sync=1 cnt=5", bus.sync_o, bus.edge_cnt); end
`ifdef IBUF_SYNC_FILTER_EN
    checks++; if (busf.stable !== 1'b0) begin failures++; $display("FAIL mid_pre_filter_stable got=%b exp=0", busf.stable); end
`endif
    rst = 1'b1;
    tick();
    checks++; if ({bus.sync_o, bus.rise, bus.fall} !== 3'b000) begin failures++; $display("FAIL mid_rst_outs got=%b exp=000", {bus.sync_o, bus.rise, bus.fall}); end
    checks++; if (bus.edge_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", bus.edge_cnt); end
    checks++; if (bus.stable !== 1'b1) begin failures++; $display("FAIL mid_rst_stable got=%b exp=1", bus.stable); end
    checks++; if (bus.O !== 1'b1) begin failures++; $display("FAIL mid_rst_O got=%b exp=1", bus.O); end
    checks++; if ({busf.sync_o, busf.stable} !== 2'b01) begin failures++; $display("FAIL mid_rst_filter got=%b exp=01", {busf.sync_o, busf.stable}); end
  endtask

  // Continues from test_reset_mid: rst high, pin high.
  task automatic test_release_high();
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if ({bus.sync_o, bus.rise} !== 2'b00) begin failures++; $display("FAIL rel_edge2 got=%b exp=00", {bus.sync_o, bus.rise}); end
    tick();
    checks++; if ({bus.sync_o, bus.rise} !== 2'b11) begin failures++; $display("FAIL rel_edge3 got=%b exp=11", {bus.sync_o, bus.rise}); end
    tick();
    checks++; if ({bus.rise, bus.edge_cnt} !== {1'b0, 16'd1}) begin failures++; $display("FAIL rel_edge4 got rise=%b cnt=%0d exp rise=0 cnt=1", bus.rise, bus.edge_cnt); end
  endtask

`ifdef IBUF_SYNC_FILTER_EN
  task automatic test_filter();
    int hi_seen = 0;
    int rise_n = 0;
    int rise_at = -1;
    int fall_at = -1;
    int stable_mid = -1;
    pin = 1'b0;
    do_reset();
    pin = 1'b1;
    repeat (10) tick();
    pin = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busf.sync_o !== 1'b0 || busf.rise !== 1'b0 || busf.fall !== 1'b0) hi_seen++;
    end
    checks++; if (hi_seen != 0) begin failures++; $display("FAIL filt_short_pass got=%0d exp=0", hi_seen); end
    checks++; if (busf.edge_cnt !== 16'd0) begin failures++; $display("FAIL filt_short_cnt got=%0d exp=0", busf.edge_cnt); end
    pin = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 31) pin = 1'b0;
      tick();
      if (k == 10) stable_mid = int'(busf.stable);
      if (busf.rise === 1'b1) begin rise_n++; rise_at = k; end
      if (busf.fall === 1'b1 && fall_at < 0) fall_at = k;
    end
    checks++; if (stable_mid != 0) begin failures++; $display("FAIL filt_stable_mid got=%0d exp=0", stable_mid); end
    checks++; if (rise_n != 1 || rise_at != 26) begin failures++; $display("FAIL filt_rise got n=%0d at=%0d exp n=1 at=26", rise_n, rise_at); end
    checks++; if (fall_at != 56) begin failures++; $display("FAIL filt_fall got at=%0d exp at=56", fall_at); end
    checks++; if ({busf.sync_o, busf.edge_cnt} !== {1'b0, 16'd1}) begin failures++; $display("FAIL filt_end got sync=%b cnt=%0d exp sync=0 cnt=1", busf.sync_o, busf.edge_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_toggle();
    test_wrap();
    test_reset_mid();
    test_release_high();
`ifdef IBUF_SYNC_FILTER_EN
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
